spe: RTL and testbench
======================

SPE -- requirements
Module: spe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - PE_ID, 0, 4-bit identity of this PE; matched against input address field.
 - THRESHOLD, 64, 25-bit unsigned firing threshold.
 - DEST_ADDR, 12, 4-bit address placed in every output packet.
REQ-002 Ports (name, direction, width, meaning), one per line:
 - clk, in, 1, single clock; all state updates on rising edge.
 - rst_n, in, 1, reset; asynchronous, active-low.
 - in_data, in, 35, input packet: [34:33] unused, [32:29] addr, [28:25] opcode, [24:0] data.
 - in_valid, in, 1, input packet offered.
 - in_ready, out, 1, SPE can accept an input packet.
 - out_data, out, 35, output packet, same field layout; [34:33] always 0.
 - out_valid, out, 1, output packet offered.
 - out_ready, in, 1, downstream accepts the output packet.

Function
REQ-003 Input transfer occurs on a rising clk edge with in_valid=1 and in_ready=1; output transfer occurs on a rising clk edge with out_valid=1 and out_ready=1.
REQ-004 in_ready SHALL be 1 only when no output packet is pending in the internal 2-entry output queue (queue empty).
REQ-005 out_data SHALL be held stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop without a transfer.
REQ-006 Accepted packets with addr != PE_ID SHALL be discarded with no state change and no output.
REQ-007 Opcode 0 (PSUM): acc <= acc + data (25-bit unsigned); no output.
REQ-008 Opcode 15 (TS_DONE): acc <= 0; ts_cnt <= ts_cnt + 1 (25-bit, wraps); enqueue one packet {DEST_ADDR, opcode 15, data = new ts_cnt}.
REQ-009 Opcode 2 (PREV_POT): pot = data + acc (26-bit sum); if pot >= THRESHOLD then spike=1, res = pot - THRESHOLD, else spike=0, res = pot; res saturates to 25'h1FFFFFF if it exceeds 25 bits; acc <= 0.
REQ-010 On PREV_POT, SPE SHALL enqueue {DEST_ADDR, opcode 2, data = res} first, then, only if spike=1, {DEST_ADDR, opcode 3, data = {21'b0, PE_ID}}.
REQ-011 Any other opcode SHALL be accepted and discarded with no state change.
REQ-012 Latency: out_valid SHALL assert on the first rising edge after the accepting edge; the second (spike) packet follows on the edge after the first transfers at the earliest.
REQ-013 The queue SHALL never overflow, given REQ-004; accepting and emitting on the same edge is not possible because the queue is nonempty whenever out_valid=1.
REQ-014 Internal state: acc (25 b), ts_cnt (25 b), 2-entry output queue with count (0..2).

Reset
REQ-015 While rst_n=0, asynchronously: acc=0, ts_cnt=0, queue empty, out_valid=0, out_data=0, in_ready=0.
REQ-016 in_ready SHALL rise on the first rising clk edge after rst_n deasserts; reset mid-transfer SHALL discard pending output packets.

Configuration
REQ-017 Macro SPE_SATURATE_EN: when defined, PSUM accumulation SHALL saturate at 25'h1FFFFFF; when undefined, acc SHALL wrap modulo 2^25.

Verification
REQ-018 PSUM data 0,1,2,3,4 (addr 0), then TS_DONE -> acc reaches 10 and is cleared; one output {12, 15, 1}.
REQ-019 PSUM 0..4, then PREV_POT 60 -> outputs {12, 2, 6}, then {12, 3, 0} (pot 70 >= 64).
REQ-020 PREV_POT 63 with acc=0 -> single output {12, 2, 63}, no spike packet.
REQ-021 out_ready held 0 for 10 cycles after PREV_POT 64 -> out_data stable at {12, 2, 0}; in_ready=0 throughout; then spike packet follows.
REQ-022 PSUM 25'h1FFFFFF then PSUM 5 -> acc = 25'h1FFFFFF with SPE_SATURATE_EN, 4 without.
REQ-023 Packet with addr 3 and opcode 0 -> discarded; subsequent PREV_POT 0 outputs {12, 2, 0}.

Source files
------------

// File: rtl/spe.sv
// Spiking PE: accumulates partial sums, fires against THRESHOLD, emits via a 2-deep queue.
// Optional build macro SPE_SATURATE_EN makes PSUM accumulation saturate instead of wrap.
module spe #(
  parameter logic [3:0]  PE_ID     = 4'd0,
  parameter logic [24:0] THRESHOLD = 25'd64,
  parameter logic [3:0]  DEST_ADDR = 4'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [34:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [34:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [3:0]  OP_PSUM = 4'd0;
  localparam logic [3:0]  OP_PREV = 4'd2;
  localparam logic [3:0]  OP_SPK  = 4'd3;
  localparam logic [3:0]  OP_TS   = 4'd15;
  localparam logic [24:0] ONES    = 25'h1FFFFFF;

  logic [24:0] acc;
  logic [24:0] ts_cnt;
  logic [34:0] q0;
  logic [34:0] q1;
  logic [1:0]  cnt;
  logic        rdy;

  logic [3:0]  addr;
  logic [3:0]  op;
  logic [24:0] data;
  logic        hit;
  logic        pop;

  logic [24:0] acc_nxt;
  logic [24:0] ts_nxt;
  logic [1:0]  push_n;
  logic [34:0] p0;
  logic [34:0] p1;

  logic [25:0] sum;
  logic [24:0] psum_acc;
  logic [25:0] pot;
  logic        spike;
  logic [25:0] res_w;
  logic [24:0] res;

  assign addr = in_data[32:29];
  assign op   = in_data[28:25];
  assign data = in_data[24:0];

  // Accept only into an empty queue, so push and pop never coincide.
  assign in_ready  = rdy && (cnt == 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = q0;

  assign hit = in_valid && in_ready && (addr == PE_ID);
  assign pop = out_valid && out_ready;

  assign sum = {1'b0, acc} + {1'b0, data};
`ifdef SPE_SATURATE_EN
  assign psum_acc = sum[25] ? ONES : sum[24:0];
`else
  assign psum_acc = sum[24:0];
`endif

  assign pot   = {1'b0, data} + {1'b0, acc};
  assign spike = (pot >= {1'b0, THRESHOLD});
  assign res_w = spike ? (pot - {1'b0, THRESHOLD}) : pot;
  assign res   = res_w[25] ? ONES : res_w[24:0];

  always_comb begin
    acc_nxt = acc;
    ts_nxt  = ts_cnt;
    push_n  = 2'd0;
    p0      = q0;
    p1      = q1;
    if (hit) begin
      unique case (1'b1)
        (op == OP_PSUM): begin
          acc_nxt = psum_acc;
        end
        (op == OP_TS): begin
          acc_nxt = '0;
          ts_nxt  = ts_cnt + 25'd1;
          push_n  = 2'd1;
          p0      = {2'b00, DEST_ADDR, OP_TS, ts_cnt + 25'd1};
        end
        (op == OP_PREV): begin
          acc_nxt = '0;
          push_n  = spike ? 2'd2 : 2'd1;
          p0      = {2'b00, DEST_ADDR, OP_PREV, res};
          p1      = {2'b00, DEST_ADDR, OP_SPK, 21'd0, PE_ID};
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      ts_cnt <= '0;
      q0     <= '0;
      q1     <= '0;
      cnt    <= 2'd0;
      rdy    <= 1'b0;
    end else begin
      rdy    <= 1'b1;
      acc    <= acc_nxt;
      ts_cnt <= ts_nxt;
      if (push_n != 2'd0) begin
        q0  <= p0;
        q1  <= p1;
        cnt <= push_n;
      end else if (pop) begin
        q0  <= q1;
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_spe.sv
// Directed vector bench for spe: table of single packets plus stall/reset sequences.
module tb_spe;

  logic        clk;
  logic        rst_n;
  logic [34:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  spe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  o;
    logic [24:0] d;
    int          n;
    logic [34:0] e0;
    logic [34:0] e1;
  } vec_t;

  vec_t tv[$];

  function automatic logic [34:0] pk(input logic [3:0] a, input logic [3:0] o,
                                     input logic [24:0] d);
    return {2'b00, a, o, d};
  endfunction

  task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] a, input logic [3:0] o, input logic [24:0] d,
                      input int n, input logic [34:0] e0, input logic [34:0] e1);
    vec_t v;
    v.a = a; v.o = o; v.d = d; v.n = n; v.e0 = e0; v.e1 = e1;
    tv.push_back(v);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] o, input logic [24:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", {34'd0, in_ready}, 35'd1);
    in_data  = pk(a, o, d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic collect(output int n, output logic [34:0] c0, output logic [34:0] c1);
    n  = 0;
    c0 = '0;
    c1 = '0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) begin
        if (n == 0) c0 = out_data;
        else if (n == 1) c1 = out_data;
        n++;
      end
    end
  endtask

  logic [34:0] held;

  initial begin
    int n;
    logic [34:0] c0;
    logic [34:0] c1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    addv(0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0);
    addv(0, 0, 2, 0, 0, 0);
    addv(0, 0, 3, 0, 0, 0);
    addv(0, 0, 4, 0, 0, 0);
    addv(0, 15, 0, 1, pk(12, 15, 1), 0);
    addv(0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0);
    addv(0, 0, 2, 0, 0, 0);
    addv(0, 0, 3, 0, 0, 0);
    addv(0, 0, 4, 0, 0, 0);
    addv(0, 2, 60, 2, pk(12, 2, 6), pk(12, 3, 0));
    addv(0, 2, 63, 1, pk(12, 2, 63), 0);
    addv(3, 0, 5, 0, 0, 0);
    addv(0, 2, 0, 1, pk(12, 2, 0), 0);
    addv(0, 7, 9, 0, 0, 0);
    addv(0, 2, 10, 1, pk(12, 2, 10), 0);
    addv(0, 15, 0, 1, pk(12, 15, 2), 0);
    addv(0, 0, 25'h1FFFFFF, 0, 0, 0);
    addv(0, 2, 25'h1FFFFFF, 2, pk(12, 2, 25'h1FFFFFF), pk(12, 3, 0));
    addv(0, 0, 1, 0, 0, 0);
    addv(0, 2, 64, 2, pk(12, 2, 1), pk(12, 3, 0));
    addv(0, 0, 25'h1FFFFFF, 0, 0, 0);
    addv(0, 0, 5, 0, 0, 0);
`ifdef SPE_SATURATE_EN
    addv(0, 2, 0, 2, pk(12, 2, 25'h1FFFFBF), pk(12, 3, 0));
`else
    addv(0, 2, 0, 1, pk(12, 2, 4), 0);
`endif
    addv(5, 15, 0, 0, 0, 0);
    addv(0, 15, 0, 1, pk(12, 15, 3), 0);

    #12;
    check("rst_in_ready", {34'd0, in_ready}, 35'd0);
    check("rst_out_valid", {34'd0, out_valid}, 35'd0);
    check("rst_out_data", out_data, 35'd0);
    #10;
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_lo", {34'd0, in_ready}, 35'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_hi", {34'd0, in_ready}, 35'd1);

    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].a, tv[i].o, tv[i].d);
      collect(n, c0, c1);
      check($sformatf("v%0d_count", i), 35'(n), 35'(tv[i].n));
      check($sformatf("v%0d_pkt0", i), c0, tv[i].e0);
      check($sformatf("v%0d_pkt1", i), c1, tv[i].e1);
    end

    out_ready = 1'b0;
    send(0, 2, 64);
    check("lat_valid", {34'd0, out_valid}, 35'd1);
    check("lat_data", out_data, pk(12, 2, 0));
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", {34'd0, out_valid}, 35'd1);
      check("stall_data", out_data, held);
      check("stall_in_ready", {34'd0, in_ready}, 35'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("spk_valid", {34'd0, out_valid}, 35'd1);
    check("spk_data", out_data, pk(12, 3, 0));
    @(posedge clk);
    #1;
    check("drain_valid", {34'd0, out_valid}, 35'd0);
    check("drain_in_ready", {34'd0, in_ready}, 35'd1);

    out_ready = 1'b0;
    send(0, 2, 100);
    @(negedge clk);
    check("pre_rst_valid", {34'd0, out_valid}, 35'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {34'd0, out_valid}, 35'd0);
    check("mid_rst_in_ready", {34'd0, in_ready}, 35'd0);
    check("mid_rst_data", out_data, 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {34'd0, in_ready}, 35'd1);
    check("post_rst_valid", {34'd0, out_valid}, 35'd0);
    send(0, 15, 0);
    collect(n, c0, c1);
    check("post_rst_ts_count", 35'(n), 35'd1);
    check("post_rst_ts_pkt", c0, pk(12, 15, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
